// File: rtl/data_mem_responder_if.sv
// Load/store request/response bundle between the MW-stage requester and the data memory.
interface data_mem_responder_if;
    logic        cs;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic        Stall_MW_DM;
    logic [31:0] data_rd;
    logic        valid_DM;
    logic        busy;

    modport master (
        output cs, wr, mask, addr, data_wr, Stall_MW_DM,
        input  data_rd, valid_DM, busy
    );

    modport slave (
        input  cs, wr, mask, addr, data_wr, Stall_MW_DM,
        output data_rd, valid_DM, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-wide data memory answering one load/store at a time after a fixed latency,
// with byte-enabled writes and a response held while the requester stalls.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             rd;
        logic [3:0]       mask;
        logic [31:0]      data;
    } req_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t           state_q, state_d;
    req_t             req_q, req_d;
    req_t             in_req, cmt_req;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      data_rd_q, data_rd_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             commit;
    logic             unused_addr;

    assign unused_addr = ^{bus.addr[31:IDX_W+2], bus.addr[1:0]};

    assign in_req.idx  = bus.addr[IDX_W+1:2];
    assign in_req.rd   = bus.wr;
    assign in_req.mask = bus.mask;
    assign in_req.data = bus.data_wr;

    // With single-cycle latency the commit happens straight from IDLE on the live inputs.
    assign cmt_req = (state_q == IDLE) ? in_req : req_q;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        cnt_d     = cnt_q;
        data_rd_d = data_rd_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.cs) begin
                    req_d = in_req;
                    if (LATENCY == 1) begin
                        commit = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 2);
                        busy_d  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                else             commit = 1'b1;
            end
            RESP: begin
                if (!bus.Stall_MW_DM) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            state_d   = RESP;
            valid_d   = 1'b1;
            busy_d    = 1'b1;
            data_rd_d = cmt_req.rd ? mem[cmt_req.idx] : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            cnt_q     <= '0;
            data_rd_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            cnt_q     <= cnt_d;
            data_rd_q <= data_rd_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    // Contents are not reset; rst gating keeps an aborted write from landing.
    always_ff @(posedge clk) begin
        if (commit && rst && !cmt_req.rd) begin
            for (int i = 0; i < 4; i++) begin
                if (cmt_req.mask[i]) mem[cmt_req.idx][8*i +: 8] <= cmt_req.data[8*i +: 8];
            end
        end
    end

    assign bus.data_rd  = data_rd_q;
    assign bus.valid_DM = valid_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 instance for the main plan, LATENCY=1 instance for the fast build.
module tb_data_mem_responder;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    data_mem_responder_if b2();
    data_mem_responder_if b1();

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request on the LATENCY=2 instance; returns cycles until valid_DM and the data seen.
    task automatic req2(input logic rd, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] d, output int lat, output logic [31:0] q);
        b2.cs = 1'b0; b2.wr = rd; b2.addr = a; b2.mask = m; b2.data_wr = d;
        lat = 0;
        do begin
            tick();
            lat++;
            b2.cs = 1'b1;
        end while (!b2.valid_DM && lat < 20);
        q = b2.data_rd;
    endtask

    initial begin
        int          lat;
        logic [31:0] q;
        checks = 0; failures = 0;
        rst = 1'b0;
        b2.cs = 1'b1; b2.wr = 1'b0; b2.mask = 4'h0; b2.addr = '0; b2.data_wr = '0; b2.Stall_MW_DM = 1'b0;
        b1.cs = 1'b1; b1.wr = 1'b0; b1.mask = 4'h0; b1.addr = '0; b1.data_wr = '0; b1.Stall_MW_DM = 1'b0;
        #3;
        chk("rst_valid", 32'(b2.valid_DM), 32'd0);
        chk("rst_busy", 32'(b2.busy), 32'd0);
        chk("rst_data", b2.data_rd, 32'h0);
        chk("rst_valid_l1", 32'(b1.valid_DM), 32'd0);
        #19 rst = 1'b1;
        tick();

        // full-word write then read
        req2(1'b0, 32'h10, 4'hF, 32'hDEADBEEF, lat, q);
        chk("wr_lat", 32'(lat), 32'd2);
        chk("wr_data_zero", q, 32'h0);
        tick();
        chk("wr_consumed_valid", 32'(b2.valid_DM), 32'd0);
        chk("wr_consumed_busy", 32'(b2.busy), 32'd0);
        req2(1'b1, 32'h10, 4'h0, 32'h0, lat, q);
        chk("rd_lat", 32'(lat), 32'd2);
        chk("rd_data", q, 32'hDEADBEEF);
        tick();

        // byte / halfword masks
        req2(1'b0, 32'h40, 4'hF, 32'hFFFFFFFF, lat, q); tick();
        req2(1'b0, 32'h40, 4'b0100, 32'h00AB0000, lat, q); tick();
        req2(1'b0, 32'h40, 4'b0011, 32'h0000CDEF, lat, q); tick();
        req2(1'b1, 32'h40, 4'h0, 32'h0, lat, q);
        chk("mask_merge", q, 32'hFFABCDEF);
        tick();
        req2(1'b0, 32'h40, 4'b0000, 32'h12345678, lat, q);
        chk("mask0_resp", 32'(lat), 32'd2);
        tick();
        req2(1'b1, 32'h40, 4'h0, 32'h0, lat, q);
        chk("mask0_unchanged", q, 32'hFFABCDEF);
        tick();

        // stall hold with cs toggling
        b2.Stall_MW_DM = 1'b1;
        req2(1'b1, 32'h40, 4'h0, 32'h0, lat, q);
        chk("stall_first", q, 32'hFFABCDEF);
        for (int k = 0; k < 3; k++) begin
            b2.cs = k[0]; b2.wr = 1'b0; b2.addr = 32'h40; b2.mask = 4'hF; b2.data_wr = 32'h0;
            tick();
            chk("stall_valid", 32'(b2.valid_DM), 32'd1);
            chk("stall_data", b2.data_rd, 32'hFFABCDEF);
            chk("stall_busy", 32'(b2.busy), 32'd1);
        end
        b2.Stall_MW_DM = 1'b0; b2.cs = 1'b1;
        tick();
        chk("stall_release_valid", 32'(b2.valid_DM), 32'd0);
        chk("stall_release_busy", 32'(b2.busy), 32'd0);
        tick();
        chk("stall_no_new_req", 32'(b2.busy), 32'd0);
        req2(1'b1, 32'h40, 4'h0, 32'h0, lat, q);
        chk("stall_cs_ignored", q, 32'hFFABCDEF);
        tick();

        // back-to-back with address alias
        req2(1'b0, 32'h0000, 4'hF, 32'h11111111, lat, q); tick();
        req2(1'b1, 32'h1000, 4'h0, 32'h0, lat, q);
        chk("alias_lat", 32'(lat), 32'd2);
        chk("alias_data", q, 32'h11111111);
        tick();

        // reset during WAIT of a write
        req2(1'b0, 32'h20, 4'hF, 32'hAAAAAAAA, lat, q); tick();
        req2(1'b1, 32'h20, 4'h0, 32'h0, lat, q); tick();
        b2.cs = 1'b0; b2.wr = 1'b0; b2.addr = 32'h20; b2.mask = 4'hF; b2.data_wr = 32'h12345678;
        tick();
        b2.cs = 1'b1;
        chk("abort_busy_before", 32'(b2.busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("abort_valid", 32'(b2.valid_DM), 32'd0);
        chk("abort_busy", 32'(b2.busy), 32'd0);
        chk("abort_data", b2.data_rd, 32'h0);
        tick();
        #2 rst = 1'b1;
        req2(1'b1, 32'h20, 4'h0, 32'h0, lat, q);
        chk("abort_mem_kept", q, 32'hAAAAAAAA);
        tick();

        // LATENCY=1 instance
        b1.cs = 1'b0; b1.wr = 1'b0; b1.addr = 32'h8; b1.mask = 4'hF; b1.data_wr = 32'h5A5A5A5A;
        tick();
        b1.cs = 1'b1;
        chk("l1_wr_valid", 32'(b1.valid_DM), 32'd1);
        tick();
        b1.cs = 1'b0; b1.wr = 1'b1;
        tick();
        b1.cs = 1'b1;
        chk("l1_rd_valid", 32'(b1.valid_DM), 32'd1);
        chk("l1_rd_busy", 32'(b1.busy), 32'd1);
        chk("l1_rd_data", b1.data_rd, 32'h5A5A5A5A);
        tick();
        chk("l1_busy_fall", 32'(b1.busy), 32'd0);
        chk("l1_valid_fall", 32'(b1.valid_DM), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Synchronous data-memory responder on the far end of the load/store interface. It accepts one request at a time from the MW-stage load/store unit, commits byte-masked writes or fetches full words after a fixed latency, and returns a one-cycle-or-held `valid_DM` response. Byte/halfword lane selection, sign extension and store-data alignment are the requester's job. This block stores only whole words and applies `mask` as byte enables.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words. Must be a power of two. The word index is `addr[$clog2(DEPTH_WORDS)+1:2]`.
- `LATENCY`, 2: cycles from request acceptance to `valid_DM` assertion. Must be ≥ 1.

- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cs`  in  1  chip select, active-low; 0 = request present
- `wr`  in  1  1 = read (load), 0 = write (store)
- `mask`  in  4  byte enables for writes; bit i enables byte lane `[8i+7:8i]`
- `addr`  in  32  byte address; `addr[1:0]` and the bits above the index are ignored
- `data_wr`  in  32  store data, already lane-aligned by the requester
- `Stall_MW_DM`  in  1  requester cannot consume the response this cycle
- `data_rd`  out  32  read word (registered)
- `valid_DM`  out  1  response valid (registered)
- `busy`  out  1  high whenever the FSM is not IDLE

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - When `cs==0` is sampled, latch word index, `wr`, `mask` and `data_wr`.
  - If `LATENCY==1`: commit immediately and go to RESP.
  - Otherwise go to WAIT with `cnt = LATENCY-2`.
- **WAIT**
  - If `cnt != 0`, decrement `cnt`.
  - If `cnt == 0`, commit and go to RESP.
  - `cs` and all request inputs are ignored; latched values are used.
- **Commit** happens on the edge that enters RESP.
  - Read: `data_rd <= mem[idx]`.
  - Write: for each i with `mask[i]=1`, `mem[idx][8i+7:8i] <= data_wr[8i+7:8i]`, and `data_rd <= 0`.
  - `mask==0` write: memory is unchanged, but the response is still issued.
- **RESP**
  - `valid_DM=1`.
  - If `Stall_MW_DM==1`, stay in RESP with `valid_DM` and `data_rd` held stable.
  - If `Stall_MW_DM==0`, the response is consumed this cycle and the FSM returns to IDLE.
  - `cs` is ignored in RESP.
- **Back-to-back:** `cs==0` seen in the IDLE cycle after RESP is a new request. The requester advances its stage on the consuming cycle.
- **Read-after-write** to the same word in consecutive requests returns the post-write value. There is no bypass hazard because the write commits before the read is accepted.
- Memory contents are not reset; they are undefined until written.

## Timing
- **Reset values:** state=IDLE, `valid_DM=0`, `data_rd=0`, `busy=0`, `cnt=0`.
- **Reset mid-operation:** the request is aborted.
  - A write whose commit edge has not occurred is never performed.
  - A write already committed is retained.
  - Outputs return to reset values asynchronously.
- **Latency:** a request sampled at edge E0 gives `valid_DM=1` from edge E0+LATENCY-1 onward (i.e. LATENCY cycles after the request cycle).
- **Throughput:** one request per LATENCY+1 cycles with no stall.
- `busy` rises in the cycle after acceptance and falls in the cycle after the consuming RESP cycle.
- `valid_DM` never rises without a preceding accepted request. It stays high for exactly 1 + (number of stalled RESP cycles) cycles.
- Address wrap: index bits above `$clog2(DEPTH_WORDS)+1` are dropped. For example, with `DEPTH_WORDS=1024`, 0x1000 aliases 0x0000.

## Test plan
- **Full-word write/read, LATENCY=2:** write 0xDEADBEEF to addr 0x10 with mask 4'b1111, then read 0x10. `valid_DM` is high 2 cycles after each request and `data_rd`=0xDEADBEEF.
- **Byte and halfword masks:** write 0xFFFFFFFF, then write `data_wr`=0x00AB0000 with mask 4'b0100, then write 0x0000CDEF with mask 4'b0011. A read returns 0xFFABCDEF. A write with mask 4'b0000 leaves the word unchanged.
- **Stall hold:** issue a read and hold `Stall_MW_DM=1` for 3 cycles in RESP. `valid_DM` stays high for 4 cycles with `data_rd` stable. Toggling `cs` during that time starts no new request.
- **Back-to-back and alias:** write 0x11111111 to 0x0000, then in the next IDLE cycle read 0x1000. The read returns 0x11111111 with no idle gap beyond IDLE.
- **Reset mid-operation:** assert `rst`=0 during WAIT of a write of 0x12345678 to 0x20, where 0x20 previously held 0xAAAAAAAA. `valid_DM`/`busy`/`data_rd` drop to 0 immediately, and a later read of 0x20 returns 0xAAAAAAAA.
- **LATENCY=1 build:** a read is answered on the cycle after acceptance, and `busy` is high for exactly 1 cycle with no stall.
